lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory-access stage between execute and the synchronous data RAM (dmem).
//  Accepts one ld/st request per cycle (valid/ready) and drives the dmem re/we/addr/wdata pins.
//  Returns load data or a store ack one cycle later (valid/ready) and flags misaligned or out-of-range accesses.
//  Keeps saturating load/store/error event counters.
// PARAMETERS
//  DMEM_WORDS   1024  words in dmem; legal byte addresses are 0 .. 4*DMEM_WORDS-1
//  RD_W         4     destination-register tag width (16 architectural regs)
//  CNT_W        16    width of each event counter
//  CHECK_RANGE  1     1: out-of-range address raises an error; 0: address wraps modulo dmem size
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      stage can accept a request
//  req_is_st  in   1      1 = store, 0 = load
//  req_addr   in   32     byte address
//  req_wdata  in   32     store data
//  req_rd     in   RD_W   load destination tag (passed through)
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer accepts response
//  rsp_data   out  32     load data; 0 for stores and errors
//  rsp_rd     out  RD_W   tag of the request being answered
//  rsp_is_st  out  1      response belongs to a store
//  rsp_err    out  1      misaligned or out-of-range access; no RAM access was made
//  mem_re     out  1      dmem read enable
//  mem_we     out  1      dmem write enable
//  mem_addr   out  32     dmem byte address (equals req_addr)
//  mem_wdata  out  32     dmem write data (equals req_wdata)
//  mem_rdata  in   32     dmem read data; valid the cycle after mem_re; held while mem_re=0
//  cnt_ld     out  CNT_W  completed loads, saturating
//  cnt_st     out  CNT_W  completed stores, saturating
//  cnt_err    out  CNT_W  error responses, saturating
// BEHAVIOUR
//  FSM states
//   - IDLE: no response pending.
//   - RESP: response pending.
//  Handshake
//   - req_ready = (state==IDLE) | (state==RESP & rsp_ready).
//   - accept = req_valid & req_ready.
//   - Once rsp_valid=1, rsp_* fields stay stable until rsp_ready.
//  Error check (combinational on req_addr)
//   - bad = (req_addr[1:0]!=0) | (CHECK_RANGE & req_addr >= 4*DMEM_WORDS).
//  dmem drive (combinational, same cycle as accept)
//   - mem_re = accept & ~req_is_st & ~bad.
//   - mem_we = accept & req_is_st & ~bad.
//   - mem_re and mem_we are never both 1.
//  State update on accept
//   - state goes to RESP; register rd, is_st and err.
//   - No accept while RESP & rsp_ready: state goes to IDLE.
//   - RESP & ~rsp_ready: hold.
//  Response data
//   - rsp_valid = (state==RESP).
//   - rsp_data = (~is_st & ~err) ? mem_rdata : 0.
//   - Stalls are safe because dmem holds rdata while mem_re=0, and no new read issues until rsp_ready.
//  Latency and throughput
//   - Request accepted at edge N gives rsp_valid from cycle N+1.
//   - Back-to-back throughput is 1 request per cycle when rsp_ready=1.
//  Counters
//   - Increment on rsp_valid & rsp_ready according to type; err responses count only in cnt_err.
//   - Counters stick at 2^CNT_W-1.
//  Reset (rst_n=0, asynchronous)
//   - state=IDLE; rsp_valid, rsp_err, rsp_is_st and rsp_rd = 0; counters = 0.
//   - mem_re and mem_we = 0 while reset is held.
//   - A pending response is dropped when reset hits mid-operation; a store already written stays in the RAM.
// TESTING
//  1. st addr 0x10 wdata 0xDEADBEEF, then ld 0x10 rd=3 -> mem_we once; rsp_data=0xDEADBEEF, rsp_rd=3 one cycle after the ld accept.
//  2. 4 back-to-back lds with rsp_ready=1 -> 4 responses on consecutive cycles in order; req_ready never drops.
//  3. ld accepted, rsp_ready=0 for 5 cycles -> rsp_data stable, req_ready=0, mem_re=0 throughout.
//  4. ld addr 0x13, then st addr 0x1000 (CHECK_RANGE=1) -> rsp_err=1 on both, mem_re=mem_we=0, cnt_err=2.
//  5. rst_n low while state=RESP -> rsp_valid drops at once; after release the next ld works.
//  6. CNT_W=2, 5 loads -> cnt_ld saturates at 3.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage between execute and dmem: issues re/we the cycle a request is accepted,
// answers one cycle later. Stalls hold the response stable; saturating ld/st/err counters.
module lsu_mem_stage #(
  parameter int DMEM_WORDS  = 1024,
  parameter int RD_W        = 4,
  parameter int CNT_W       = 16,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_st,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [RD_W-1:0]  req_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [RD_W-1:0]  rsp_rd,
  output logic             rsp_is_st,
  output logic             rsp_err,
  output logic             mem_re,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] cnt_ld,
  output logic [CNT_W-1:0] cnt_st,
  output logic [CNT_W-1:0] cnt_err
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DMEM_WORDS);

  state_t          state;
  logic [RD_W-1:0] rd_q;
  logic            is_st_q;
  logic            err_q;
  logic            bad;
  logic            accept;
  logic            fire;

  assign bad = (req_addr[1:0] != 2'b00) |
               (CHECK_RANGE & ({1'b0, req_addr} >= ADDR_LIMIT));

  assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
  // Gating with rst_n keeps the RAM pins quiet while reset is held.
  assign accept    = req_valid & req_ready & rst_n;

  assign mem_re    = accept & ~req_is_st & ~bad;
  assign mem_we    = accept &  req_is_st & ~bad;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  assign rsp_valid = (state == RESP);
  assign rsp_rd    = rd_q;
  assign rsp_is_st = is_st_q;
  assign rsp_err   = err_q;
  // dmem holds rdata while no read is issued, so a stalled load stays stable.
  assign rsp_data  = (~is_st_q & ~err_q) ? mem_rdata : 32'd0;

  assign fire = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_q    <= '0;
      is_st_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      state   <= RESP;
      rd_q    <= req_rd;
      is_st_q <= req_is_st;
      err_q   <= bad;
    end else if ((state == RESP) && rsp_ready) begin
      state   <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ld  <= '0;
      cnt_st  <= '0;
      cnt_err <= '0;
    end else if (fire) begin
      if (err_q) begin
        if (cnt_err != '1) cnt_err <= cnt_err + 1'b1;
      end else if (is_st_q) begin
        if (cnt_st != '1) cnt_st <= cnt_st + 1'b1;
      end else begin
        if (cnt_ld != '1) cnt_ld <= cnt_ld + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed vector table, stall/reset/saturation sequences,
// then random traffic checked against a transaction-level reference model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_st;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_rd;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_rd;
  logic        rsp_is_st, rsp_err;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  cnt_ld, cnt_st, cnt_err;

  always #5 clk = ~clk;

  lsu_mem_stage #(.DMEM_WORDS(1024), .RD_W(4), .CNT_W(2), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_st(req_is_st),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_is_st(rsp_is_st), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_err(cnt_err)
  );

  // Synchronous dmem: read data appears the cycle after mem_re and is held otherwise.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[11:2]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding response, shadow memory, counters as integers.
  logic [31:0] mm [0:1023];
  bit          m_pend;
  logic [31:0] m_data;
  logic [31:0] m_rd;
  bit          m_st, m_err, m_acc, m_bad;
  int          m_ld, m_stc, m_errc;

  function automatic int sat3(input int n);
    return (n >= 3) ? 3 : n + 1;
  endfunction

  task automatic m_reset();
    m_pend = 0; m_ld = 0; m_stc = 0; m_errc = 0;
  endtask

  // Apply inputs (called just after a falling edge) and check all outputs against the model.
  task automatic drive(input bit v, input bit st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] rd, input bit rr);
    req_valid = v; req_is_st = st; req_addr = a; req_wdata = wd; req_rd = rd; rsp_ready = rr;
    #1;
    m_bad = (a % 4 != 0) || (a >= 32'd4096);
    m_acc = v && (!m_pend || rr);
    chk1("req_ready", req_ready, !m_pend || rr);
    chk1("mem_re", mem_re, m_acc && !st && !m_bad);
    chk1("mem_we", mem_we, m_acc && st && !m_bad);
    if (m_acc && !m_bad) begin
      chk32("mem_addr", mem_addr, a);
      if (st) chk32("mem_wdata", mem_wdata, wd);
    end
    chk1("rsp_valid", rsp_valid, m_pend);
    if (m_pend) begin
      chk32("rsp_data", rsp_data, m_data);
      chk32("rsp_rd", 32'(rsp_rd), m_rd);
      chk1("rsp_is_st", rsp_is_st, m_st);
      chk1("rsp_err", rsp_err, m_err);
    end
    chk32("cnt_ld", 32'(cnt_ld), m_ld);
    chk32("cnt_st", 32'(cnt_st), m_stc);
    chk32("cnt_err", 32'(cnt_err), m_errc);
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (m_pend && rsp_ready) begin
      if (m_err)     m_errc = sat3(m_errc);
      else if (m_st) m_stc  = sat3(m_stc);
      else           m_ld   = sat3(m_ld);
    end
    if (m_acc) begin
      m_pend = 1; m_rd = 32'(req_rd); m_st = req_is_st; m_err = m_bad;
      m_data = 32'd0;
      if (!m_bad) begin
        if (req_is_st) mm[req_addr / 4] = req_wdata;
        else           m_data = mm[req_addr / 4];
      end
    end else if (rsp_ready) begin
      m_pend = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_is_st = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 4'd0;
    rsp_ready = 1'b0;
    #1;
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_rsp_is_st", rsp_is_st, 1'b0);
    chk32("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk1("rst_mem_re", mem_re, 1'b0);
    chk32("rst_cnt_ld", 32'(cnt_ld), 32'd0);
    chk32("rst_cnt_err", 32'(cnt_err), 32'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] v, st, a, wd, rd, rr;
    logic [31:0] e_rdy, e_re, e_we, e_vld, e_data, e_rd, e_st, e_err, e_cld, e_cst, e_cerr;
  } vec_t;

  vec_t tv [7];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      mm[i]  = ram[i];
    end
    //            v st a          wd            rd rr  rdy re we vld data          rd st er  ld st er
    tv[0] = '{1, 1, 32'h10,   32'hDEADBEEF, 0, 1,  1, 0, 1, 0, 0,            0, 0, 0,  0, 0, 0};
    tv[1] = '{1, 0, 32'h10,   0,            3, 1,  1, 1, 0, 1, 0,            0, 1, 0,  0, 0, 0};
    tv[2] = '{0, 0, 0,        0,            0, 1,  1, 0, 0, 1, 32'hDEADBEEF, 3, 0, 0,  0, 1, 0};
    tv[3] = '{1, 0, 32'h13,   0,            5, 1,  1, 0, 0, 0, 0,            0, 0, 0,  1, 1, 0};
    tv[4] = '{1, 1, 32'h1000, 32'h1234,     0, 1,  1, 0, 0, 1, 0,            5, 0, 1,  1, 1, 0};
    tv[5] = '{0, 0, 0,        0,            0, 1,  1, 0, 0, 1, 0,            0, 1, 1,  1, 1, 1};
    tv[6] = '{0, 0, 0,        0,            0, 1,  1, 0, 0, 0, 0,            0, 0, 0,  1, 1, 2};

    @(negedge clk);
    do_reset();

    // Store then load, followed by misaligned load and out-of-range store.
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].v[0], tv[i].st[0], tv[i].a, tv[i].wd, tv[i].rd[3:0], tv[i].rr[0]);
      chk1("t_req_ready", req_ready, tv[i].e_rdy[0]);
      chk1("t_mem_re", mem_re, tv[i].e_re[0]);
      chk1("t_mem_we", mem_we, tv[i].e_we[0]);
      chk1("t_rsp_valid", rsp_valid, tv[i].e_vld[0]);
      if (tv[i].e_vld[0]) begin
        chk32("t_rsp_data", rsp_data, tv[i].e_data);
        chk32("t_rsp_rd", 32'(rsp_rd), tv[i].e_rd);
        chk1("t_rsp_is_st", rsp_is_st, tv[i].e_st[0]);
        chk1("t_rsp_err", rsp_err, tv[i].e_err[0]);
      end
      chk32("t_cnt_ld", 32'(cnt_ld), tv[i].e_cld);
      chk32("t_cnt_st", 32'(cnt_st), tv[i].e_cst);
      chk32("t_cnt_err", 32'(cnt_err), tv[i].e_cerr);
      tick();
    end

    // Four back-to-back loads with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'(32'h40 + 4 * i), 32'h0, 4'(8 + i), 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
    tick();

    // Load held for five stalled cycles while another request waits.
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'd2, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h24, 32'h0, 4'd6, 1'b0);
      chk1("stall_req_ready", req_ready, 1'b0);
      chk32("stall_rsp_data", rsp_data, mm[8]);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
    tick();

    // Reset while a response is pending, then a load of the earlier store.
    drive(1'b1, 1'b0, 32'h44, 32'h0, 4'd1, 1'b1);
    tick();
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'd7, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
    chk32("post_reset_ld_data", rsp_data, 32'hDEADBEEF);
    tick();

    // Load counter saturation with a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(4 * i), 32'h0, 4'd0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
    chk32("cnt_ld_saturated", 32'(cnt_ld), 32'd3);
    tick();

    // Random traffic, including range/alignment boundaries.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r, a;
      int          mode;
      r    = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0:       a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(1, 3));
        1:       a = 32'h1000 + 32'(4 * $urandom_range(0, 3));
        2:       a = 32'hFFC;
        3:       a = $urandom | 32'h8000_0000;
        default: a = 32'(4 * $urandom_range(0, 15));
      endcase
      drive(r[0] | r[1], r[2], a, $urandom, r[7:4], r[8] | r[9]);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
